// File: rtl/vga_object_motion_ctrl.sv
// vga_object_motion_ctrl: per-frame sequencer that moves and bounces a square on a VGA frame.
// Latency: obj_x settles 2 clocks after the frame-end clock, obj_y after 3, bounce_count/colour after 4.
// Backpressure: none; frame-end events seen outside S_WAIT are dropped. Optional macro: OBJ_BOUNCE_COLOR_EN.
module vga_object_motion_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int OBJ_SIZE  = 40,
  parameter int INIT_X    = 300,
  parameter int INIT_Y    = 220
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] pixel_X_pos,
  input  logic [9:0] pixel_Y_pos,
  input  logic [2:0] speed_i,
  input  logic       pause_i,
  output logic       object_on,
  output logic [9:0] obj_x,
  output logic [9:0] obj_y,
  output logic       frame_tick,
  output logic [7:0] bounce_count,
  output logic [7:0] obj_red,
  output logic [7:0] obj_green,
  output logic [7:0] obj_blue
);

  localparam logic [10:0] XMAX11 = 11'(H_VISIBLE - OBJ_SIZE);
  localparam logic [10:0] YMAX11 = 11'(V_VISIBLE - OBJ_SIZE);
  localparam logic [9:0]  XMAX10 = 10'(H_VISIBLE - OBJ_SIZE);
  localparam logic [9:0]  YMAX10 = 10'(V_VISIBLE - OBJ_SIZE);
  localparam logic [10:0] SIZE11 = 11'(OBJ_SIZE);

  typedef enum logic [1:0] {S_WAIT, S_UPD_X, S_UPD_Y, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_obj_x, r_obj_y;
  logic        r_dir_x, r_dir_y;        // 1 = increasing
  logic [2:0]  r_spd_q;
  logic        r_pause_q;
  logic        r_bounce_flag;
  logic [7:0]  r_bounce_cnt;
  logic        r_frame_tick;

  logic        w_frame_end, w_start, w_hold;
  logic [10:0] w_x_fwd, w_y_fwd;
  logic [9:0]  w_x_back, w_y_back;
  logic        w_x_hit_hi, w_x_hit_lo, w_y_hit_hi, w_y_hit_lo;
  logic [10:0] w_px, w_py, w_ox, w_oy;

  assign w_frame_end = enable && (pixel_X_pos == 10'(H_VISIBLE - 1))
                              && (pixel_Y_pos == 10'(V_VISIBLE - 1));
  assign w_start     = w_frame_end && (r_state == S_WAIT);
  // A paused frame or zero speed still walks the FSM but freezes motion.
  assign w_hold      = r_pause_q || (r_spd_q == 3'd0);

  // 11-bit forward sums so the right/bottom edge test cannot wrap.
  assign w_x_fwd    = {1'b0, r_obj_x} + {8'b0, r_spd_q};
  assign w_y_fwd    = {1'b0, r_obj_y} + {8'b0, r_spd_q};
  assign w_x_back   = r_obj_x - {7'b0, r_spd_q};
  assign w_y_back   = r_obj_y - {7'b0, r_spd_q};
  assign w_x_hit_hi = (w_x_fwd >= XMAX11);
  assign w_y_hit_hi = (w_y_fwd >= YMAX11);
  assign w_x_hit_lo = (r_obj_x <= {7'b0, r_spd_q});
  assign w_y_hit_lo = (r_obj_y <= {7'b0, r_spd_q});

  // Frame sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_WAIT;
    else       r_state <= w_state_nxt;
  end

  // Next-state: one pass X -> Y -> DONE per accepted frame end.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:  if (w_frame_end) w_state_nxt = S_UPD_X;
      S_UPD_X: w_state_nxt = S_UPD_Y;
      S_UPD_Y: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_WAIT;
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // Position, direction, bounce bookkeeping and frame tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_obj_x       <= 10'(INIT_X);
      r_obj_y       <= 10'(INIT_Y);
      r_dir_x       <= 1'b1;
      r_dir_y       <= 1'b1;
      r_spd_q       <= 3'd0;
      r_pause_q     <= 1'b0;
      r_bounce_flag <= 1'b0;
      r_bounce_cnt  <= 8'd0;
      r_frame_tick  <= 1'b0;
    end else begin
      r_frame_tick <= w_start;
      if (w_start) begin
        r_spd_q       <= speed_i;
        r_pause_q     <= pause_i;
        r_bounce_flag <= 1'b0;
      end
      if (r_state == S_UPD_X && !w_hold) begin
        if (r_dir_x) begin
          if (w_x_hit_hi) begin
            r_obj_x <= XMAX10; r_dir_x <= 1'b0; r_bounce_flag <= 1'b1;
          end else begin
            r_obj_x <= w_x_fwd[9:0];
          end
        end else begin
          if (w_x_hit_lo) begin
            r_obj_x <= 10'd0; r_dir_x <= 1'b1; r_bounce_flag <= 1'b1;
          end else begin
            r_obj_x <= w_x_back;
          end
        end
      end
      if (r_state == S_UPD_Y && !w_hold) begin
        if (r_dir_y) begin
          if (w_y_hit_hi) begin
            r_obj_y <= YMAX10; r_dir_y <= 1'b0; r_bounce_flag <= 1'b1;
          end else begin
            r_obj_y <= w_y_fwd[9:0];
          end
        end else begin
          if (w_y_hit_lo) begin
            r_obj_y <= 10'd0; r_dir_y <= 1'b1; r_bounce_flag <= 1'b1;
          end else begin
            r_obj_y <= w_y_back;
          end
        end
      end
      // The flag is shared by both axes, so a corner hit counts once.
      if (r_state == S_DONE && r_bounce_flag) r_bounce_cnt <= r_bounce_cnt + 8'd1;
    end
  end

  assign w_px = {1'b0, pixel_X_pos};
  assign w_py = {1'b0, pixel_Y_pos};
  assign w_ox = {1'b0, r_obj_x};
  assign w_oy = {1'b0, r_obj_y};
  assign object_on = (w_px >= w_ox) && (w_px < w_ox + SIZE11) &&
                     (w_py >= w_oy) && (w_py < w_oy + SIZE11);

`ifdef OBJ_BOUNCE_COLOR_EN
  logic [2:0] r_color_idx;

  // Colour index steps 7 -> 1 -> ... -> 7 on each bounce frame, never 0 (black).
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 r_color_idx <= 3'd7;
    else if (r_state == S_DONE && r_bounce_flag) r_color_idx <= (r_color_idx == 3'd7) ? 3'd1 : r_color_idx + 3'd1;
  end

  assign obj_red   = (object_on && r_color_idx[2]) ? 8'hFF : 8'h00;
  assign obj_green = (object_on && r_color_idx[1]) ? 8'hFF : 8'h00;
  assign obj_blue  = (object_on && r_color_idx[0]) ? 8'hFF : 8'h00;
`else
  assign obj_red   = object_on ? 8'hFF : 8'h00;
  assign obj_green = object_on ? 8'hFF : 8'h00;
  assign obj_blue  = object_on ? 8'hFF : 8'h00;
`endif

  assign obj_x        = r_obj_x;
  assign obj_y        = r_obj_y;
  assign frame_tick   = r_frame_tick;
  assign bounce_count = r_bounce_cnt;

endmodule

// File: doc/vga_object_motion_ctrl.md
# vga_object_motion_ctrl

Per-frame sequencer for the VGA moving-object display. It watches the pixel coordinate stream from the VGA controller and detects the end of each visible frame. During vertical blanking it advances the square's position by a switch-selected speed, bouncing off the screen edges. It drives `object_on` and the RGB colour back to the top level, so the object moves without tearing.

## Interface
Parameters:
- `H_VISIBLE`, 640: visible columns.
- `V_VISIBLE`, 480: visible rows.
- `OBJ_SIZE`, 40: square edge in pixels.
- `INIT_X`, 300: reset column of the top-left corner.
- `INIT_Y`, 220: reset row of the top-left corner.

Ports:
- `clock` in 1: 50 MHz system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: 25 MHz pixel strobe, high every other `clock`.
- `pixel_X_pos` in 10: current column from the VGA controller.
- `pixel_Y_pos` in 10: current row from the VGA controller.
- `speed_i` in 3: pixels per frame on each axis, 0–7.
- `pause_i` in 1: freezes motion while high.
- `object_on` out 1: current pixel lies inside the square.
- `obj_x` out 10: top-left column of the square.
- `obj_y` out 10: top-left row of the square.
- `frame_tick` out 1: one-`clock` pulse per frame end.
- `bounce_count` out 8: number of edge bounces, wrapping.
- `obj_red`, `obj_green`, `obj_blue` out 8 each: object colour.

## Operation
- Frame-end event: `enable`=1, `pixel_X_pos`=H_VISIBLE-1 and `pixel_Y_pos`=V_VISIBLE-1.
- On the event, `pause_i` and `speed_i` are sampled into `spd_q`/`pause_q`.
- FSM states:
  - S_WAIT: on the event, go to S_UPD_X.
  - S_UPD_X: update x and `dir_x`; go to S_UPD_Y.
  - S_UPD_Y: update y and `dir_y`; go to S_DONE.
  - S_DONE: update `bounce_count` and colour; go to S_WAIT.
- If `pause_q`=1 or `spd_q`=0, positions, directions and `bounce_count` are held. The FSM still walks all states.
- X update, using an 11-bit intermediate and XMAX = H_VISIBLE-OBJ_SIZE:
  - `dir_x`=+ and `obj_x`+spd ≥ XMAX: `obj_x`←XMAX, `dir_x`←−, set bounce flag.
  - `dir_x`=− and `obj_x` ≤ spd: `obj_x`←0, `dir_x`←+, set bounce flag.
  - Otherwise `obj_x` moves by ±spd.
- Y update: identical, with YMAX = V_VISIBLE-OBJ_SIZE.
- A corner hit (X and Y bounce in the same frame) increments `bounce_count` by 1, not 2. `bounce_count` wraps 255→0.
- `object_on` is combinational. It is 1 when `obj_x` ≤ `pixel_X_pos` < `obj_x`+OBJ_SIZE and `obj_y` ≤ `pixel_Y_pos` < `obj_y`+OBJ_SIZE.
- Colour outputs are 8'h00 when `object_on`=0.

## Timing
- Reset values:
  - `obj_x`=INIT_X, `obj_y`=INIT_Y.
  - `dir_x` and `dir_y` = + (increasing).
  - State S_WAIT; `frame_tick`=0; `bounce_count`=0.
  - Colour index 7 (white).
- `frame_tick` is registered: high the `clock` after the event, for exactly one `clock`.
- Latency from the event `clock` to settled outputs:
  - `obj_x`: 2 `clock`.
  - `obj_y`: 3 `clock`.
  - `bounce_count` and colour: 4 `clock`.
- All updates finish inside blanking. The visible region never sees a partially updated position.
- `object_on` has zero latency relative to the coordinate inputs.
- A frame-end event arriving outside S_WAIT is ignored. This cannot occur at legal VGA timing.
- A `reset` assertion in any state forces reset values immediately. Motion restarts at the next event after deassertion.

## Configuration
- Macro: `OBJ_BOUNCE_COLOR_EN`.
- Defined: a 3-bit colour index starts at 7 and increments once per bounce frame in S_DONE, sequence 7→1→2…→7, skipping 0.
  - Each channel is 8'hFF when its index bit is set: bit2 red, bit1 green, bit0 blue.
- Undefined: no index register exists. The colour is constant white (8'hFF on all three channels); `bounce_count` still operates.

## Test plan
- Reset mid-frame -> `obj_x`=300, `obj_y`=220, `bounce_count`=0, `frame_tick`=0, white; after release, zero motion until the first frame end.
- `speed_i`=1, one frame end -> `frame_tick` pulses one `clock`; `obj_x`=301 after 2 `clock`; `obj_y`=221 after 3 `clock`.
- `speed_i`=7, run to the right edge -> `obj_x` clamps to 600 and `bounce_count`=1; next frame `obj_x`=593.
- Top-left corner: start `dir` −,− at (3,3), `speed_i`=5 -> (0,0), both directions +, `bounce_count` +1 only.
- `pause_i`=1 for 3 frames -> `obj_x`, `obj_y` and `bounce_count` unchanged; `frame_tick` still pulses 3 times.
- With `obj_x`=300, `obj_y`=220:
  - Pixel (300,220) and pixel (339,259) -> `object_on`=1.
  - Pixel (340,220) and pixel (300,260) -> `object_on`=0.
- With `OBJ_BOUNCE_COLOR_EN` defined: first bounce -> colour index 1 (`obj_blue`=FF, red and green 00). Without it -> all channels FF.
